// File: rtl/vga_mem_pkg.sv
// Shared types and default sizes for the game-state RAM arbiter.
// Slot encodes who owns the RAM this cycle; src records whose read data returns next cycle.
package vga_mem_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {SRC_NONE, SRC_VGA, SRC_GAME} src_t;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_VGA, SLOT_GAME, SLOT_WR} slot_t;

    // Only read slots produce returning data; drains and idle cycles do not.
    function automatic src_t slot_to_src(input slot_t s);
        case (s)
            SLOT_VGA:  return SRC_VGA;
            SLOT_GAME: return SRC_GAME;
            default:   return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/state_wr_fifo.sv
// Write buffer for game-logic stores, with a combinational youngest-match search
// used to forward pending data to game reads.
module state_wr_fifo #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data,
    input  logic [ADDR_W-1:0]        srch_addr,
    output logic                     srch_hit,
    output logic [DATA_W-1:0]        srch_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;
    logic [PTR_W-1:0]  idx;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last hit wins; only registered entries are visible.
    always_comb begin
        srch_hit  = 1'b0;
        srch_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == srch_addr)) begin
                srch_hit  = 1'b1;
                srch_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port state RAM arbiter: VGA reads always win, game reads next, buffered
// game writes drain in free cycles (or forcibly when the buffer is full).
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vga_re,
    input  logic [ADDR_W-1:0]             vga_raddr,
    output logic [DATA_W-1:0]             vga_rdata,
    output logic                          vga_rvalid,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_gnt,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    slot_t             slot;
    src_t              tag_q, tag_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_W-1:0] rd_hold_q, rd_hold_d;

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              srch_hit;
    logic [DATA_W-1:0] srch_data;

    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_valid && wr_ready;
    assign fifo_pop  = (slot == SLOT_WR);

    state_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_addr (head_addr),
        .head_data (head_data),
        .srch_addr (rd_addr),
        .srch_hit  (srch_hit),
        .srch_data (srch_data)
    );

    // Slot is gated by reset so the RAM sees no access while reset is held.
    always_comb begin
        slot = SLOT_IDLE;
        if (!reset)                   slot = SLOT_IDLE;
        else if (vga_re)              slot = SLOT_VGA;
        else if (fifo_full && rd_req) slot = SLOT_WR;
        else if (rd_req)              slot = SLOT_GAME;
        else if (!fifo_empty)         slot = SLOT_WR;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (slot)
            SLOT_VGA: begin
                mem_en   = 1'b1;
                mem_addr = vga_raddr;
            end
            SLOT_GAME: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end
            SLOT_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            default: ;
        endcase
    end

    assign rd_gnt     = (slot == SLOT_GAME);
    assign vga_rvalid = (tag_q == SRC_VGA);
    assign vga_rdata  = vga_rvalid ? mem_rdata : '0;
    assign rd_valid   = (tag_q == SRC_GAME);
    assign rd_data    = rd_valid ? (fwd_hit_q ? fwd_data_q : mem_rdata) : rd_hold_q;

    always_comb begin
        tag_d      = slot_to_src(slot);
        fwd_hit_d  = fwd_hit_q;
        fwd_data_d = fwd_data_q;
        rd_hold_d  = rd_hold_q;
        if (slot == SLOT_GAME) begin
            fwd_hit_d  = srch_hit;
            fwd_data_d = srch_data;
        end
        if (rd_valid) begin
            rd_hold_d = rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q      <= SRC_NONE;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            rd_hold_q  <= '0;
        end else begin
            tag_q      <= tag_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a behavioural RAM and queue scoreboards
// for VGA reads, game reads (including forwarding) and drained writes.
module tb_vga_mem_arbiter;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vga_re = 1'b0;
    logic [9:0]  vga_raddr = '0;
    logic [15:0] vga_rdata;
    logic        vga_rvalid;
    logic        rd_req = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        rd_gnt;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_valid = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic [2:0]  fifo_count;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] ram     [1024];
    logic [15:0] ref_ram [1024];
    logic [15:0] vga_q [$];
    logic [15:0] rd_q  [$];
    wr_t         wq    [$];
    logic [15:0] last_rd = '0;

    int checks = 0;
    int failures = 0;

    vga_mem_arbiter #(.ADDR_W(10), .DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_re     (vga_re),
        .vga_raddr  (vga_raddr),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .fifo_count (fifo_count),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears the cycle after the read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_expect(input logic [9:0] a);
        logic [15:0] e;
        e = ref_ram[a];
        foreach (wq[i]) if (wq[i].addr == a) e = wq[i].data;
        return e;
    endfunction

    // Bookkeeping at the sample point: record what each accepted transaction must return.
    task automatic sample();
        wr_t w;
        @(negedge clk);
        if (reset) begin
            if (vga_re) vga_q.push_back(ref_ram[vga_raddr]);
            if (rd_req && rd_gnt) rd_q.push_back(rd_expect(rd_addr));
            if (wr_valid && wr_ready) begin
                w.addr = wr_addr;
                w.data = wr_data;
                wq.push_back(w);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            sample();
            adv();
        end
    endtask

    task automatic game_read(input logic [9:0] a);
        logic got;
        got = 1'b0;
        rd_req  = 1'b1;
        rd_addr = a;
        for (int k = 0; k < 20 && !got; k++) begin
            sample();
            if (rd_gnt) got = 1'b1;
            adv();
        end
        chk("rd_gnt_seen", 32'(got), 32'd1);
        rd_req = 1'b0;
    endtask

    task automatic vga_readback(input logic [9:0] a0, input int n);
        vga_re = 1'b1;
        for (int k = 0; k < n; k++) begin
            vga_raddr = a0 + 10'(k);
            sample();
            adv();
        end
        vga_re = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            vga_q.delete();
            rd_q.delete();
            wq.delete();
            last_rd = '0;
        end else begin
            if (vga_rvalid) begin
                chk("vga_q_nonempty", 32'(vga_q.size() != 0), 32'd1);
                if (vga_q.size() != 0) chk("vga_rdata", 32'(vga_rdata), 32'(vga_q.pop_front()));
            end else begin
                chk("vga_rdata_idle", 32'(vga_rdata), 32'd0);
            end
            if (rd_valid) begin
                chk("rd_q_nonempty", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    last_rd = rd_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(last_rd));
                end
            end else begin
                chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
            end
            if (mem_en && mem_we) begin
                chk("wq_nonempty", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    chk("drain_addr", 32'(mem_addr), 32'(e.addr));
                    chk("drain_data", 32'(mem_wdata), 32'(e.data));
                    ref_ram[e.addr] = e.data;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 16'hC000 | 16'(i);
            ref_ram[i] = 16'hC000 | 16'(i);
        end
        cyc(3);
        #1 reset = 1'b1;
        adv();

        // Reset asserted in the middle of a VGA read with a write pending.
        vga_re = 1'b1; vga_raddr = 10'h005;
        wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 16'hDEAD;
        sample();
        chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
        wr_valid = 1'b0;
        #1 reset = 1'b0;
        adv();
        sample();
        chk("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        vga_re = 1'b0;
        #1 reset = 1'b1;
        adv();
        sample();
        chk("post_rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
        chk("post_rst_fifo_count", 32'(fifo_count), 32'd0);
        adv();

        // VGA beats a concurrent game read; the game read follows.
        vga_re = 1'b1; vga_raddr = 10'h010;
        rd_req = 1'b1; rd_addr = 10'h020;
        sample();
        chk("vga_win_addr", 32'(mem_addr), 32'h010);
        chk("vga_win_gnt", 32'(rd_gnt), 32'd0);
        adv();
        vga_re = 1'b0;
        sample();
        chk("vga_rvalid_n1", 32'(vga_rvalid), 32'd1);
        chk("vga_rdata_n1", 32'(vga_rdata), 32'hC010);
        chk("game_gnt_after", 32'(rd_gnt), 32'd1);
        adv();
        rd_req = 1'b0;
        cyc(2);

        // Fill the FIFO under continuous VGA traffic, then let it drain in order.
        vga_re = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_addr = 10'(1 + k); wr_data = 16'hA001 + 16'(k);
            sample();
            adv();
        end
        wr_valid = 1'b0;
        sample();
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        adv();
        vga_re = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("drain_we", 32'(mem_we), 32'd1);
            chk("drain_order", 32'(mem_addr), 32'(1 + k));
            adv();
        end
        sample();
        chk("drained_count", 32'(fifo_count), 32'd0);
        adv();
        vga_readback(10'h001, 4);
        cyc(2);

        // Two pending writes to one address; game read forwards the younger one.
        vga_re = 1'b1; vga_raddr = 10'h000;
        wr_valid = 1'b1; wr_addr = 10'h030; wr_data = 16'h1111;
        sample(); adv();
        wr_data = 16'h2222;
        sample(); adv();
        wr_valid = 1'b0; vga_re = 1'b0;
        game_read(10'h030);
        sample();
        chk("fwd_rd_valid", 32'(rd_valid), 32'd1);
        chk("fwd_rd_data", 32'(rd_data), 32'h2222);
        chk("fwd_before_drain", 32'(fifo_count), 32'd2);
        adv();
        cyc(4);
        vga_readback(10'h030, 1);
        cyc(2);

        // Full FIFO with a waiting game read: a drain goes first.
        vga_re = 1'b1; vga_raddr = 10'h011;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_addr = 10'h050 + 10'(k); wr_data = 16'hD000 + 16'(k);
            sample(); adv();
        end
        wr_valid = 1'b0; vga_re = 1'b0;
        rd_req = 1'b1; rd_addr = 10'h040;
        sample();
        chk("starve_we", 32'(mem_we), 32'd1);
        chk("starve_gnt", 32'(rd_gnt), 32'd0);
        chk("starve_count", 32'(fifo_count), 32'd4);
        adv();
        sample();
        chk("after_drain_count", 32'(fifo_count), 32'd3);
        chk("after_drain_gnt", 32'(rd_gnt), 32'd1);
        adv();
        rd_req = 1'b0;
        cyc(5);
        vga_readback(10'h050, 4);
        cyc(2);

        // Push and drain together at count 2, wrapping the pointers three times.
        vga_re = 1'b1; vga_raddr = 10'h012;
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1; wr_addr = 10'h100 + 10'(k); wr_data = 16'hB000 + 16'(k);
            sample(); adv();
        end
        vga_re = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wr_valid = 1'b1; wr_addr = 10'h102 + 10'(k); wr_data = 16'hB002 + 16'(k);
            sample();
            chk("steady_count", 32'(fifo_count), 32'd2);
            chk("steady_we", 32'(mem_we), 32'd1);
            adv();
        end
        wr_valid = 1'b0;
        sample();
        chk("steady_final_count", 32'(fifo_count), 32'd2);
        adv();
        cyc(4);
        vga_readback(10'h100, 14);
        cyc(4);

        chk("vga_q_empty", 32'(vga_q.size()), 32'd0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
